// File: rtl/morse_player.sv
// Plays a 5-symbol Morse code (bit4 first, 1 = dash) as a timed tone with
// start/busy/done handshake. All outputs registered; en=0 freezes everything.
module morse_player #(
    parameter int UNIT_CYCLES    = 25000000,
    parameter int DOT_UNITS      = 1,
    parameter int DASH_UNITS     = 3,
    parameter int GAP_UNITS      = 1,
    parameter int CHAR_GAP_UNITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [4:0] morse_cord,
    output logic       tone_out,
    output logic       busy,
    output logic       done
);
    localparam int MAXA = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
    localparam int MAXB = (GAP_UNITS > CHAR_GAP_UNITS) ? GAP_UNITS : CHAR_GAP_UNITS;
    localparam int MAXU = (MAXA > MAXB) ? MAXA : MAXB;
    localparam int CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int UW   = (MAXU > 1) ? $clog2(MAXU) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, CHAR_GAP} state_t;

    state_t        state, state_nx;
    logic [4:0]    sh, sh_nx;
    logic [2:0]    sym, sym_nx;
    logic [CW-1:0] cyc, cyc_nx;
    logic [UW-1:0] unit, unit_nx;
    logic          tone_nx, busy_nx, done_nx;
    logic [UW-1:0] len_m1;
    logic          phase_end;

    // Length of the current phase in units, minus one
    always_comb begin
        len_m1 = '0;
        unique case (state)
            IDLE:     len_m1 = '0;
            MARK:     len_m1 = sh[4] ? UW'(DASH_UNITS - 1) : UW'(DOT_UNITS - 1);
            GAP:      len_m1 = UW'(GAP_UNITS - 1);
            CHAR_GAP: len_m1 = UW'(CHAR_GAP_UNITS - 1);
        endcase
    end

    assign phase_end = (cyc == CYC_LAST) && (unit == len_m1);

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        sym_nx   = sym;
        cyc_nx   = cyc;
        unit_nx  = unit;
        tone_nx  = tone_out;
        busy_nx  = busy;
        done_nx  = done;
        if (en) begin
            done_nx = 1'b0;
            if (state != IDLE) begin
                if (cyc == CYC_LAST) begin
                    cyc_nx  = '0;
                    unit_nx = unit + 1'b1;
                end else begin
                    cyc_nx = cyc + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    tone_nx = 1'b0;
                    busy_nx = 1'b0;
                    if (start) begin
                        sh_nx    = morse_cord;
                        sym_nx   = 3'd0;
                        cyc_nx   = '0;
                        unit_nx  = '0;
                        state_nx = MARK;
                        tone_nx  = 1'b1;
                        busy_nx  = 1'b1;
                    end
                end
                MARK: begin
                    if (phase_end) begin
                        cyc_nx  = '0;
                        unit_nx = '0;
                        tone_nx = 1'b0;
                        if (sym != 3'd4) begin
                            sh_nx    = {sh[3:0], 1'b0};
                            sym_nx   = sym + 3'd1;
                            state_nx = GAP;
                        end else begin
                            state_nx = CHAR_GAP;
                        end
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        cyc_nx   = '0;
                        unit_nx  = '0;
                        tone_nx  = 1'b1;
                        state_nx = MARK;
                    end
                end
                CHAR_GAP: begin
                    if (phase_end) begin
                        cyc_nx   = '0;
                        unit_nx  = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            sym      <= '0;
            cyc      <= '0;
            unit     <= '0;
            tone_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            sh       <= sh_nx;
            sym      <= sym_nx;
            cyc      <= cyc_nx;
            unit     <= unit_nx;
            tone_out <= tone_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end
endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: per-cycle scoreboard of {tone,busy,done} built from
// the Morse timing rules, plus table-driven per-character totals.
module tb_morse_player;
    localparam int U = 4;

    logic       clk, rst, en, start;
    logic [4:0] morse_cord;
    logic       tone_out, busy, done;

    morse_player #(.UNIT_CYCLES(U)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .morse_cord(morse_cord),
        .tone_out(tone_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {logic tone; logic busy; logic done;} obs_t;
    typedef struct {logic [4:0] code; int busy_cyc; int tone_cyc;} vec_t;

    obs_t exp_q[$];
    obs_t last_exp;
    int   n_cmp, n_bad;
    int   busy_n, tone_n, done_n;

    task automatic chk_obs(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: tone/busy/done got %b, expected %b", name, $time, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Expected per-cycle outputs for one character, starting with the accept edge
    task automatic push_char(input logic [4:0] c);
        for (int s = 0; s < 5; s++) begin
            int ml;
            ml = (c[4-s] ? 3 : 1) * U;
            repeat (ml) exp_q.push_back(obs_t'(3'b110));
            if (s < 4) repeat (U) exp_q.push_back(obs_t'(3'b010));
        end
        repeat (3 * U) exp_q.push_back(obs_t'(3'b010));
        exp_q.push_back(obs_t'(3'b001));
    endtask

    task automatic step(input string name);
        logic r, e;
        obs_t want;
        r = rst;
        e = en;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            want = '0;
        end else if (!e) begin
            want = last_exp;
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
        end else begin
            want = '0;
        end
        last_exp = want;
        if (e && !r) begin
            if (busy) busy_n++;
            if (tone_out) tone_n++;
            if (done) done_n++;
        end
        chk_obs(name, {tone_out, busy, done}, want);
    endtask

    task automatic run_to_idle(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            step(name);
            guard++;
        end
        if (exp_q.size() > 0) chk_int({name, " timeout"}, exp_q.size(), 0);
    endtask

    task automatic clr_counts();
        busy_n = 0;
        tone_n = 0;
        done_n = 0;
    endtask

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; last_exp = '0;
        rst = 1'b1; en = 1'b1; start = 1'b0; morse_cord = 5'b0;
        clr_counts();

        vecs[0] = '{5'b00000, 48, 20};
        vecs[1] = '{5'b01111, 80, 52};
        vecs[2] = '{5'b11111, 88, 60};
        vecs[3] = '{5'b10101, 72, 44};
        vecs[4] = '{5'b00001, 56, 28};

        // Reset then idle
        repeat (2) step("reset");
        rst = 1'b0;
        repeat (5) step("idle");

        // Table: one character each, check waveform and totals
        foreach (vecs[i]) begin
            morse_cord = vecs[i].code;
            clr_counts();
            start = 1'b1;
            push_char(vecs[i].code);
            step("accept");
            start = 1'b0;
            run_to_idle("play");
            chk_int("busy_cycles", busy_n, vecs[i].busy_cyc);
            chk_int("tone_cycles", tone_n, vecs[i].tone_cyc);
            chk_int("done_pulses", done_n, 1);
            repeat (3) step("idle_after");
        end

        // start while busy with a new code: ignored; then start held across done
        morse_cord = 5'b01111;
        start = 1'b1;
        push_char(5'b01111);
        step("accept2");
        start = 1'b0;
        repeat (20) step("mid");
        morse_cord = 5'b00000;
        start = 1'b1;
        step("start_busy");
        start = 1'b0;
        repeat (40) step("mid2");
        morse_cord = 5'b10101;
        start = 1'b1;
        push_char(5'b10101);
        clr_counts();
        while (done_n == 0 && exp_q.size() > 0) step("b2b_first");
        chk_int("b2b_done_seen", done_n, 1);
        step("b2b_mark");
        chk_int("b2b_tone_after_done", int'(tone_out), 1);
        start = 1'b0;
        run_to_idle("b2b_second");
        repeat (2) step("idle_b2b");

        // en dropped mid-dash
        morse_cord = 5'b01111;
        clr_counts();
        start = 1'b1;
        push_char(5'b01111);
        step("accept_en");
        start = 1'b0;
        repeat (9) step("pre_freeze");
        en = 1'b0;
        repeat (10) step("freeze");
        en = 1'b1;
        run_to_idle("post_freeze");
        chk_int("en_tone_cycles", tone_n, 52);
        chk_int("en_busy_cycles", busy_n, 80);

        // rst during third symbol, and rst beats start
        clr_counts();
        morse_cord = 5'b00000;
        start = 1'b1;
        push_char(5'b00000);
        step("accept_rst");
        start = 1'b0;
        repeat (17) step("pre_rst");
        rst = 1'b1;
        start = 1'b1;
        step("rst_abort");
        rst = 1'b0;
        start = 1'b0;
        repeat (20) step("after_rst");
        chk_int("rst_no_done", done_n, 0);

        clr_counts();
        morse_cord = 5'b10101;
        start = 1'b1;
        push_char(5'b10101);
        step("accept_post_rst");
        start = 1'b0;
        run_to_idle("post_rst_play");
        chk_int("post_rst_busy", busy_n, 72);
        chk_int("post_rst_done", done_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
